// File: rtl/mips_pkg.sv
// Shared definitions for the fetch stage: opcodes and branch counter encodings.
package mips_pkg;

  localparam logic [5:0] OPC_BEQ = 6'h04;
  localparam logic [5:0] OPC_BNE = 6'h05;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } bht_cnt_e;

  localparam bht_cnt_e BHT_RESET = WNT;

  // Saturating 2-bit counter step: taken moves toward ST, not-taken toward SNT.
  function automatic bht_cnt_e counterNext(input bht_cnt_e cur, input logic taken);
    bht_cnt_e nxt;
    nxt = cur;
    case (cur)
      SNT:     nxt = taken ? WNT : SNT;
      WNT:     nxt = taken ? WT  : SNT;
      WT:      nxt = taken ? ST  : WNT;
      ST:      nxt = taken ? ST  : WT;
      default: nxt = cur;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/fetch_stage_bht.sv
// Untagged table of 2-bit branch counters: one combinational read port and
// one synchronous update port. A same-index read during an update sees the
// old value; the new one appears after the edge.
module branch_history_table
  import mips_pkg::*;
#(
  parameter int ENTRIES = 64,
  parameter int IDX     = $clog2(ENTRIES)
) (
  input  logic           i_clock,
  input  logic           i_reset,
  input  logic [IDX-1:0] i_rdIndex,
  output bht_cnt_e       o_rdCounter,
  input  logic           i_updEn,
  input  logic [IDX-1:0] i_updIndex,
  input  logic           i_updTaken
);

  bht_cnt_e r_counters [ENTRIES];

  assign o_rdCounter = r_counters[i_rdIndex];

  // Reset every counter to weakly not-taken; otherwise train the addressed one.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_counters[i] <= BHT_RESET;
      end
    end else if (i_updEn) begin
      r_counters[i_updIndex] <= counterNext(r_counters[i_updIndex], i_updTaken);
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC register, branch predecode and next-PC selection.
// Redirects from later stages win over stall; the BHT only steers PC when
// nothing else is in control of it.
module fetch_stage
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          BHT_ENTRIES = 64
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        stall,
  input  logic [31:0] instructionROMOut,
  input  logic        Branch_out,
  input  logic [31:0] branchTarget,
  input  logic        Jump_out,
  input  logic [31:0] jumpTarget,
  input  logic        bhtUpdate,
  input  logic [31:0] bhtUpdatePC,
  input  logic        bhtTaken,
  output logic [31:0] pc,
  output logic [31:0] pcPlus4,
  output logic        prediction
);

  localparam int IDX = $clog2(BHT_ENTRIES);

  logic [31:0] r_pc;
  logic [31:0] w_pcPlus4;
  logic [5:0]  w_opcode;
  logic [15:0] w_imm;
  logic        w_isBranch;
  logic [31:0] w_offset;
  logic [31:0] w_predTarget;
  bht_cnt_e    w_counter;
  logic        w_prediction;
  logic [31:0] w_nextPc;
  logic        w_unusedBits;

  assign w_pcPlus4    = r_pc + 32'd4;
  assign w_opcode     = instructionROMOut[31:26];
  assign w_imm        = instructionROMOut[15:0];
  assign w_isBranch   = (w_opcode == OPC_BEQ) || (w_opcode == OPC_BNE);
  assign w_offset     = {{14{w_imm[15]}}, w_imm, 2'b00};
  assign w_predTarget = w_pcPlus4 + w_offset;
  assign w_prediction = w_isBranch & w_counter[1];

  assign w_unusedBits = ^{instructionROMOut[25:16], bhtUpdatePC[31:IDX+2], bhtUpdatePC[1:0]};

  branch_history_table #(
    .ENTRIES(BHT_ENTRIES),
    .IDX    (IDX)
  ) u_bht (
    .i_clock    (clock),
    .i_reset    (reset),
    .i_rdIndex  (r_pc[IDX+1:2]),
    .o_rdCounter(w_counter),
    .i_updEn    (bhtUpdate),
    .i_updIndex (bhtUpdatePC[IDX+1:2]),
    .i_updTaken (bhtTaken)
  );

  // Next-PC priority: branch redirect, jump, stall, predicted taken, sequential.
  always_comb begin
    w_nextPc = w_pcPlus4;
    if (Branch_out) begin
      w_nextPc = branchTarget;
    end else if (Jump_out) begin
      w_nextPc = jumpTarget;
    end else if (stall) begin
      w_nextPc = r_pc;
    end else if (w_prediction) begin
      w_nextPc = w_predTarget;
    end
  end

  // PC register, forced to the reset vector asynchronously.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_pc <= RESET_PC;
    end else begin
      r_pc <= w_nextPc;
    end
  end

  assign pc         = r_pc;
  assign pcPlus4    = w_pcPlus4;
  assign prediction = w_prediction;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed vector bench for fetch_stage: table of single-cycle vectors plus
// hand sequences for reset at power-up and asynchronous reset mid-cycle.
module tb_fetch_stage;

  localparam logic [31:0] NOP    = 32'h0000_0000;
  localparam logic [31:0] BEQ3   = 32'h1000_0003;
  localparam logic [31:0] BEQM2  = 32'h1000_FFFE;
  localparam logic [31:0] BNE1   = 32'h1400_0001;
  localparam logic [31:0] JMP3   = 32'h0800_0003;

  logic        clock;
  logic        reset;
  logic        stall;
  logic [31:0] instructionROMOut;
  logic        Branch_out;
  logic [31:0] branchTarget;
  logic        Jump_out;
  logic [31:0] jumpTarget;
  logic        bhtUpdate;
  logic [31:0] bhtUpdatePC;
  logic        bhtTaken;
  logic [31:0] pc;
  logic [31:0] pcPlus4;
  logic        prediction;

  int compareCount = 0;
  int failCount    = 0;

  typedef struct {
    logic        stall;
    logic        branch;
    logic [31:0] bTarget;
    logic        jump;
    logic [31:0] jTarget;
    logic [31:0] rom;
    logic        upd;
    logic [31:0] updPC;
    logic        taken;
    logic        expPred;
    logic [31:0] expPc;
  } vec_t;

  vec_t vecs[$];

  fetch_stage #(
    .RESET_PC   (32'h0000_0000),
    .BHT_ENTRIES(64)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .stall            (stall),
    .instructionROMOut(instructionROMOut),
    .Branch_out       (Branch_out),
    .branchTarget     (branchTarget),
    .Jump_out         (Jump_out),
    .jumpTarget       (jumpTarget),
    .bhtUpdate        (bhtUpdate),
    .bhtUpdatePC      (bhtUpdatePC),
    .bhtTaken         (bhtTaken),
    .pc               (pc),
    .pcPlus4          (pcPlus4),
    .prediction       (prediction)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic vec_t mk(input logic st, input logic br, input logic [31:0] bt,
                              input logic jp, input logic [31:0] jt, input logic [31:0] rom,
                              input logic up, input logic [31:0] upc, input logic tk,
                              input logic ep, input logic [31:0] epc);
    vec_t v;
    v.stall = st; v.branch = br; v.bTarget = bt; v.jump = jp; v.jTarget = jt;
    v.rom = rom; v.upd = up; v.updPC = upc; v.taken = tk;
    v.expPred = ep; v.expPc = epc;
    return v;
  endfunction

  task automatic applyStimulus(input vec_t v);
    stall             = v.stall;
    Branch_out        = v.branch;
    branchTarget      = v.bTarget;
    Jump_out          = v.jump;
    jumpTarget        = v.jTarget;
    instructionROMOut = v.rom;
    bhtUpdate         = v.upd;
    bhtUpdatePC       = v.updPC;
    bhtTaken          = v.taken;
  endtask

  task automatic checkOutput(input string name, input int idx,
                             input logic [31:0] actual, input logic [31:0] expected);
    compareCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s step%0d: got %h, want %h", name, idx, actual, expected);
    end
  endtask

  // Called at a falling edge: drive, check prediction, clock, check PC.
  task automatic runVector(input vec_t v, input int idx);
    applyStimulus(v);
    #1;
    checkOutput("prediction", idx, {31'b0, prediction}, {31'b0, v.expPred});
    @(posedge clock);
    #1;
    checkOutput("pc", idx, pc, v.expPc);
    checkOutput("pcPlus4", idx, pcPlus4, v.expPc + 32'd4);
    @(negedge clock);
  endtask

  initial begin
    // Main table; starts at pc 0 with every counter weakly not-taken.
    vecs.push_back(mk(0,0,0,0,0,NOP,  0,0,0,        0,32'h4));
    vecs.push_back(mk(0,0,0,0,0,NOP,  0,0,0,        0,32'h8));
    vecs.push_back(mk(1,0,0,0,0,NOP,  1,32'h10,1,   0,32'h8));
    vecs.push_back(mk(1,0,0,0,0,NOP,  1,32'h10,1,   0,32'h8));
    vecs.push_back(mk(1,0,0,0,0,NOP,  1,32'h20,1,   0,32'h8));
    vecs.push_back(mk(0,0,0,0,0,NOP,  1,32'h20,1,   0,32'hC));
    vecs.push_back(mk(0,0,0,0,0,NOP,  1,32'h20,1,   0,32'h10));
    vecs.push_back(mk(0,0,0,0,0,BEQ3, 0,0,0,        1,32'h20));
    vecs.push_back(mk(0,0,0,0,0,BEQM2,0,0,0,        1,32'h1C));
    vecs.push_back(mk(0,0,0,0,0,NOP,  0,0,0,        0,32'h20));
    vecs.push_back(mk(0,0,0,0,0,BNE1, 0,0,0,        1,32'h28));
    vecs.push_back(mk(1,1,32'h100,1,32'h40,NOP,0,0,0,0,32'h100));
    vecs.push_back(mk(1,0,0,1,32'h40,NOP,0,0,0,     0,32'h40));
    vecs.push_back(mk(0,1,32'h10,0,0,NOP,0,0,0,     0,32'h10));
    vecs.push_back(mk(0,0,0,0,0,JMP3, 0,0,0,        0,32'h14));
    vecs.push_back(mk(1,0,0,0,0,NOP,  1,32'h10,0,   0,32'h14));
    vecs.push_back(mk(1,0,0,0,0,NOP,  1,32'h10,0,   0,32'h14));
    vecs.push_back(mk(1,0,0,0,0,NOP,  1,32'h10,0,   0,32'h14));
    vecs.push_back(mk(1,0,0,0,0,NOP,  1,32'h10,0,   0,32'h14));
    vecs.push_back(mk(1,0,0,0,0,NOP,  1,32'h10,1,   0,32'h14));
    vecs.push_back(mk(0,1,32'h10,0,0,NOP,0,0,0,     0,32'h10));
    vecs.push_back(mk(1,0,0,0,0,BEQ3, 1,32'h10,1,   0,32'h10));
    vecs.push_back(mk(0,0,0,0,0,BEQ3, 0,0,0,        1,32'h20));
    vecs.push_back(mk(0,1,32'hFFFF_FFFC,0,0,BEQ3,0,0,0,1,32'hFFFF_FFFC));
    vecs.push_back(mk(0,0,0,0,0,NOP,  0,0,0,        0,32'h0));
    vecs.push_back(mk(0,0,0,0,0,NOP,  0,0,0,        0,32'h4));

    // Power-up reset held across two rising edges.
    reset = 1'b0;
    applyStimulus(mk(0,0,0,0,0,NOP,0,0,0,0,0));
    for (int c = 0; c < 2; c++) begin
      @(negedge clock);
      checkOutput("rst_pc", c, pc, 32'h0);
      checkOutput("rst_pcPlus4", c, pcPlus4, 32'h4);
      checkOutput("rst_prediction", c, {31'b0, prediction}, 32'h0);
    end
    reset = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      runVector(vecs[i], i);
    end

    // Asynchronous reset mid-cycle with a branch redirect pending.
    #2;
    reset        = 1'b0;
    Branch_out   = 1'b1;
    branchTarget = 32'h100;
    #1;
    checkOutput("async_pc", 100, pc, 32'h0);
    checkOutput("async_pcPlus4", 100, pcPlus4, 32'h4);
    @(posedge clock);
    #1;
    checkOutput("async_hold_pc", 101, pc, 32'h0);
    @(negedge clock);
    reset      = 1'b1;
    Branch_out = 1'b0;

    // Counters at 0x10 (was 10) and 0x20 (was 11) must be back to 01.
    runVector(mk(0,1,32'h10,0,0,NOP,0,0,0,   0,32'h10), 200);
    runVector(mk(1,0,0,0,0,BEQ3,1,32'h10,1,  0,32'h10), 201);
    runVector(mk(0,0,0,0,0,BEQ3,0,0,0,       1,32'h20), 202);
    runVector(mk(0,0,0,0,0,BNE1,0,0,0,       0,32'h24), 203);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage sitting directly upstream of the IF/ID pipeline register.
- Owns the PC and drives the asynchronous-read instruction ROM address.
- Predecodes the returned word and uses a 2-bit-counter branch history table (BHT) to steer PC for conditional branches.
- Supplies pcPlus4 and prediction to IF/ID; accepts redirects (Branch_out, Jump_out) and predictor training from later stages.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- BHT_ENTRIES, 64, number of 2-bit counters; power of 2, >= 2; IDX = log2(BHT_ENTRIES).

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- stall  in  1  hazard-unit stall; hold PC.
- instructionROMOut  in  32  ROM read data for address pc (combinational ROM).
- Branch_out  in  1  EX-stage branch redirect (mispredict correction).
- branchTarget  in  32  correct next PC when Branch_out=1.
- Jump_out  in  1  jump redirect.
- jumpTarget  in  32  jump destination when Jump_out=1.
- bhtUpdate  in  1  train the BHT this cycle.
- bhtUpdatePC  in  32  PC of the resolved branch.
- bhtTaken  in  1  resolved branch outcome.
- pc  out  32  ROM address / current fetch PC (registered).
- pcPlus4  out  32  pc + 4, to IF/ID.
- prediction  out  1  predicted-taken flag for the current fetch, to IF/ID.

Behaviour:
- Reset (reset=0, asynchronous, any time including mid-redirect):
  - pc = RESET_PC.
  - All BHT counters = 2'b01 (weakly not-taken).
  - Hence pcPlus4 = RESET_PC+4 and prediction = 0 while in reset.
- pcPlus4 = pc + 4, combinational, modulo 2^32 (32'hFFFF_FFFC -> 0).
- Predecode, combinational on instructionROMOut:
  - isBranch = opcode[31:26] is BEQ (6'h04) or BNE (6'h05).
  - offset = sign-extended imm[15:0] << 2.
  - predTarget = pcPlus4 + offset, modulo 2^32.
- prediction = isBranch & bht[pc[IDX+1:2]][1], combinational.
- Next-PC priority, evaluated at each rising edge:
  1. Branch_out=1 -> branchTarget; overrides stall and Jump_out.
  2. Jump_out=1 -> jumpTarget; overrides stall.
  3. stall=1 -> pc held.
  4. prediction=1 -> predTarget.
  5. Otherwise -> pcPlus4.
- Fetch latency: the PC change is visible one cycle after the edge. ROM data and prediction for the new pc are valid in that same cycle. No bubbles on sequential fetch.
- BHT training (bhtUpdate=1), at the edge:
  - Counter at bhtUpdatePC[IDX+1:2] saturating-increments if bhtTaken=1, else decrements. Range 00..11; 11+taken stays 11; 00+not-taken stays 00.
  - Training is independent of stall, Branch_out and Jump_out.
- Same-index read/update collision: prediction in that cycle uses the pre-update counter; the new value applies from the next cycle.
- The BHT is untagged; aliasing between PCs with equal index bits is accepted.
- Bits pc[1:0] are never checked; targets are used as given.

Decomposition:
- Shared package (mips_pkg):
  - OPC_BEQ = 6'h04, OPC_BNE = 6'h05.
  - 2-bit counter encodings: SNT = 00, WNT = 01, WT = 10, ST = 11.
  - Counter reset value WNT.
- Sub-module branch_history_table:
  - Counter array with one combinational read port (index) and one synchronous update port (index, taken, enable).
  - Asynchronous active-low reset.
- fetch_stage holds the PC register, predecode and next-PC mux.

Test Plan:
- Reset and sequential fetch: hold reset=0 for 2 cycles, then release; ROM returns NOP (32'h0). Required: pc = 0 and pcPlus4 = 4 during reset, then pc = 4, 8, 12 on successive edges, prediction = 0 throughout.
- Train and predict: pulse bhtUpdate twice with bhtUpdatePC = 32'h10, bhtTaken = 1 (counter 01 -> 11). Fetch at pc = 32'h10 with ROM = 32'h1000_0003 (beq, imm 3). Required: prediction = 1, next pc = 32'h20. Repeat at pc = 32'h20 with imm 16'hFFFE, same index trained. Required: next pc = 32'h1C.
- Redirect priority: assert stall = 1, Jump_out = 1 (jumpTarget 32'h40) and Branch_out = 1 (branchTarget 32'h100) in the same cycle. Required: pc = 32'h100. Jump_out with stall only -> pc = 32'h40.
- Stall hold: stall = 1 for 3 cycles at pc = 32'h8. Required: pc stays 32'h8, pcPlus4 stays 32'hC. Release -> pc = 32'hC.
- Saturation and collision: from counter 11, apply 4 not-taken updates. Required: counter reaches 00 and stays 00. One taken update -> 01, prediction = 0. Updating the index currently being fetched -> prediction changes only in the following cycle.
- Wrap and async reset: Branch_out to 32'hFFFF_FFFC with a NOP fetched. Required: next pc = 0. Drive reset low mid-cycle. Required: pc = RESET_PC immediately, all counters back to 01.
